issue_stage: RTL and testbench

In-order issue stage directly upstream of the backend (exu → mem → wb). It buffers decoded instructions in a small FIFO and reads the register file for the head entry. It holds the head while any in-flight older instruction still has to write one of its source registers, then presents the instruction to the backend with a one-cycle `pipeval` strobe. It also drops younger buffered instructions on a backend redirect.

---
 rtl/issue_stage_pkg.sv | 42 ++++
 rtl/issue_stage_scoreboard.sv | 94 +++++++++
 rtl/issue_stage.sv | 207 ++++++++++++++++++++
 tb/tb_issue_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_stage_pkg.sv
// Shared definitions for the in-order issue stage: field widths, the packed
// control-bundle layout and default pipeline parameters.
package issue_stage_pkg;

    // Field widths (logical register, source operand, pc, instruction word)
    localparam int LREG_W  = 5;
    localparam int SRC_W   = 64;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    // Width of the opaque control bundle carried alongside each instruction
    localparam int CTRL_W = 32;

    // Issue-to-regfile-write distance (exu, mem, wb)
    localparam int WB_LAT_DEFAULT = 3;

    typedef logic [LREG_W-1:0]  lreg_t;
    typedef logic [SRC_W-1:0]   src_t;
    typedef logic [PC_W-1:0]    pc_t;
    typedef logic [INSTR_W-1:0] instr_t;

    // Control bundle layout; the issue stage only stores and forwards it
    typedef struct packed {
        logic [10:0] reserved;
        logic [2:0]  ls_size;
        logic        is_csr;
        logic        is_jump;
        logic        is_branch;
        logic        is_store;
        logic        is_load;
        logic [3:0]  muldiv_type;
        logic [4:0]  alu_type;
        logic [3:0]  cx_type;
    } ctrl_t;

    // True when the backend write port is producing the value of register rs
    function automatic logic wb_hit(input logic wb_valid, input lreg_t wb_rd,
                                    input lreg_t rs);
        return wb_valid && (wb_rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/issue_stage_scoreboard.sv
// issue_scoreboard: shift register tracking the destinations of the last
// WB_LAT issued instructions, plus the two source-busy comparators.
// With ISSUE_WB_BYPASS_EN the last slot is left out of the busy check because
// its value is forwarded from the write-back port instead.
module issue_scoreboard
    import issue_stage_pkg::*;
#(
    parameter int WB_LAT = WB_LAT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue,
    input  logic [4:0]  issue_rd,
    input  logic        issue_need_to_wb,
    input  logic        stall,
    input  logic [4:0]  rs1,
    input  logic        rs1_is_reg,
    input  logic [4:0]  rs2,
    input  logic        rs2_is_reg,
    output logic        busy1,
    output logic        busy2
);

`ifdef ISSUE_WB_BYPASS_EN
    localparam logic [WB_LAT-1:0] CHECK_MASK = {WB_LAT{1'b1}} >> 1;
`else
    localparam logic [WB_LAT-1:0] CHECK_MASK = {WB_LAT{1'b1}};
`endif

    logic        slot_valid [WB_LAT];
    logic [4:0]  slot_rd    [WB_LAT];
    logic        slot_wb    [WB_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < WB_LAT; gi++) begin : g_slot
            logic       valid_reg;
            logic [4:0] rd_reg;
            logic       wb_reg;

            if (gi == 0) begin : g_head
                // First slot captures the instruction issued this cycle
                always_ff @(posedge clock) begin
                    if (reset) begin
                        valid_reg <= 1'b0;
                        rd_reg    <= '0;
                        wb_reg    <= 1'b0;
                    end else if (!stall) begin
                        valid_reg <= issue;
                        rd_reg    <= issue_rd;
                        wb_reg    <= issue_need_to_wb;
                    end
                end
            end else begin : g_shift
                // Later slots advance one stage per unstalled cycle
                always_ff @(posedge clock) begin
                    if (reset) begin
                        valid_reg <= 1'b0;
                        rd_reg    <= '0;
                        wb_reg    <= 1'b0;
                    end else if (!stall) begin
                        valid_reg <= slot_valid[gi-1];
                        rd_reg    <= slot_rd[gi-1];
                        wb_reg    <= slot_wb[gi-1];
                    end
                end
            end

            assign slot_valid[gi] = valid_reg;
            assign slot_rd[gi]    = rd_reg;
            assign slot_wb[gi]    = wb_reg;
        end
    endgenerate

    logic hit1;
    logic hit2;

    // Compare each source against every pending writer still in flight
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (CHECK_MASK[i] && slot_valid[i] && slot_wb[i]) begin
                if (slot_rd[i] == rs1) hit1 = 1'b1;
                if (slot_rd[i] == rs2) hit2 = 1'b1;
            end
        end
    end

    // x0 is never produced, so it never blocks
    assign busy1 = rs1_is_reg && (rs1 != 5'd0) && hit1;
    assign busy2 = rs2_is_reg && (rs2 != 5'd0) && hit2;

endmodule

// File: rtl/issue_stage.sv
// issue_stage: in-order issue buffer in front of the exu/mem/wb backend.
// Buffers decoded instructions in a DEPTH-entry FIFO, reads operands for the
// head entry, holds it on RAW hazards and issues with a one-cycle pipeval.
// A redirect on the issuing instruction discards all younger buffered work.
// Optional feature macro: ISSUE_WB_BYPASS_EN (forward the write-back port).
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WB_LAT = WB_LAT_DEFAULT,
    parameter int CTRL_W = issue_stage_pkg::CTRL_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [4:0]               in_rd,
    input  logic                     in_src1_is_reg,
    input  logic                     in_src2_is_reg,
    input  logic                     in_need_to_wb,
    input  logic [63:0]              in_imm,
    input  logic [63:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic [CTRL_W-1:0]        in_ctrl,
    output logic [4:0]               rf_rs1_addr,
    output logic [4:0]               rf_rs2_addr,
    input  logic [63:0]              rf_rs1_data,
    input  logic [63:0]              rf_rs2_data,
    input  logic                     rf_write_valid,
    input  logic [4:0]               rf_write_rd,
    input  logic [63:0]              rf_write_data,
    input  logic                     mem_stall,
    input  logic                     redirect_valid,
    output logic                     pipeval,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rd,
    output logic [63:0]              src1,
    output logic [63:0]              src2,
    output logic [63:0]              imm,
    output logic                     src1_is_reg,
    output logic                     src2_is_reg,
    output logic                     need_to_wb,
    output logic [CTRL_W-1:0]        ctrl,
    output logic [63:0]              pc,
    output logic [31:0]              instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic busy1, busy2;
    logic flush, push_en, pop;

    // Per-entry storage views used by the head mux
    logic [4:0]        rs1_arr    [DEPTH];
    logic [4:0]        rs2_arr    [DEPTH];
    logic [4:0]        rd_arr     [DEPTH];
    logic              s1reg_arr  [DEPTH];
    logic              s2reg_arr  [DEPTH];
    logic              wb_arr     [DEPTH];
    logic [63:0]       imm_arr    [DEPTH];
    logic [63:0]       pc_arr     [DEPTH];
    logic [31:0]       instr_arr  [DEPTH];
    logic [CTRL_W-1:0] ctrl_arr   [DEPTH];

    assign in_ready = (count_reg != CNT_W'(DEPTH));
    assign pipeval  = (count_reg != '0) && !mem_stall && !busy1 && !busy2;
    assign pop      = pipeval;
    assign flush    = pipeval && redirect_valid;
    assign push_en  = in_valid && in_ready && !flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [4:0]        rs1_reg, rs2_reg, rd_reg;
            logic              s1reg_reg, s2reg_reg, wb_reg;
            logic [63:0]       imm_reg, pc_reg;
            logic [31:0]       instr_reg;
            logic [CTRL_W-1:0] ctrl_reg;

            // Capture a pushed instruction into the entry the write pointer selects
            always_ff @(posedge clock) begin
                if (reset) begin
                    rs1_reg   <= '0;
                    rs2_reg   <= '0;
                    rd_reg    <= '0;
                    s1reg_reg <= 1'b0;
                    s2reg_reg <= 1'b0;
                    wb_reg    <= 1'b0;
                    imm_reg   <= '0;
                    pc_reg    <= '0;
                    instr_reg <= '0;
                    ctrl_reg  <= '0;
                end else if (push_en && (wr_ptr_reg == PTR_W'(gi))) begin
                    rs1_reg   <= in_rs1;
                    rs2_reg   <= in_rs2;
                    rd_reg    <= in_rd;
                    s1reg_reg <= in_src1_is_reg;
                    s2reg_reg <= in_src2_is_reg;
                    wb_reg    <= in_need_to_wb;
                    imm_reg   <= in_imm;
                    pc_reg    <= in_pc;
                    instr_reg <= in_instr;
                    ctrl_reg  <= in_ctrl;
                end
            end

            assign rs1_arr[gi]   = rs1_reg;
            assign rs2_arr[gi]   = rs2_reg;
            assign rd_arr[gi]    = rd_reg;
            assign s1reg_arr[gi] = s1reg_reg;
            assign s2reg_arr[gi] = s2reg_reg;
            assign wb_arr[gi]    = wb_reg;
            assign imm_arr[gi]   = imm_reg;
            assign pc_arr[gi]    = pc_reg;
            assign instr_arr[gi] = instr_reg;
            assign ctrl_arr[gi]  = ctrl_reg;
        end
    endgenerate

    // Pointer/occupancy update; a redirect empties the buffer behind the issuer
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = wr_ptr_reg;
            count_next  = '0;
        end else begin
            if (push_en) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            if (pop)     rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            count_next = count_reg + CNT_W'(push_en) - CNT_W'(pop);
        end
    end

    // FIFO control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Head entry drives the backend directly
    assign rs1         = rs1_arr[rd_ptr_reg];
    assign rs2         = rs2_arr[rd_ptr_reg];
    assign rd          = rd_arr[rd_ptr_reg];
    assign src1_is_reg = s1reg_arr[rd_ptr_reg];
    assign src2_is_reg = s2reg_arr[rd_ptr_reg];
    assign need_to_wb  = wb_arr[rd_ptr_reg];
    assign imm         = imm_arr[rd_ptr_reg];
    assign pc          = pc_arr[rd_ptr_reg];
    assign instr       = instr_arr[rd_ptr_reg];
    assign ctrl        = ctrl_arr[rd_ptr_reg];
    assign count       = count_reg;

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    logic [63:0] rs1_val, rs2_val;

`ifdef ISSUE_WB_BYPASS_EN
    // A value being written back this cycle is newer than the regfile copy
    assign rs1_val = wb_hit(rf_write_valid, rf_write_rd, rs1) ? rf_write_data : rf_rs1_data;
    assign rs2_val = wb_hit(rf_write_valid, rf_write_rd, rs2) ? rf_write_data : rf_rs2_data;
`else
    logic unused_wb_port;
    assign unused_wb_port = ^{rf_write_valid, rf_write_rd, rf_write_data};
    assign rs1_val = rf_rs1_data;
    assign rs2_val = rf_rs2_data;
`endif

    // Non-register sources carry a stored value of zero
    assign src1 = src1_is_reg ? rs1_val : 64'd0;
    assign src2 = src2_is_reg ? rs2_val : 64'd0;

    issue_scoreboard #(
        .WB_LAT (WB_LAT)
    ) u_scoreboard (
        .clock            (clock),
        .reset            (reset),
        .issue            (pipeval),
        .issue_rd         (rd),
        .issue_need_to_wb (need_to_wb),
        .stall            (mem_stall),
        .rs1              (rs1),
        .rs1_is_reg       (src1_is_reg),
        .rs2              (rs2),
        .rs2_is_reg       (src2_is_reg),
        .busy1            (busy1),
        .busy2            (busy2)
    );

endmodule

// File: tb/tb_issue_stage.sv
// Directed self-checking bench for issue_stage (DEPTH=4, WB_LAT=3).
// Honours ISSUE_WB_BYPASS_EN for the dependent-pair spacing and forwarding.
module tb_issue_stage;

    localparam int DEPTH  = 4;
    localparam int WB_LAT = 3;
    localparam int CTRL_W = 32;
`ifdef ISSUE_WB_BYPASS_EN
    localparam int DEP_GAP = WB_LAT;
    localparam bit BYP     = 1'b1;
`else
    localparam int DEP_GAP = WB_LAT + 1;
    localparam bit BYP     = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic              in_src1_is_reg, in_src2_is_reg, in_need_to_wb;
    logic [63:0]       in_imm, in_pc;
    logic [31:0]       in_instr;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        rf_rs1_addr, rf_rs2_addr;
    logic [63:0]       rf_rs1_data, rf_rs2_data;
    logic              rf_write_valid;
    logic [4:0]        rf_write_rd;
    logic [63:0]       rf_write_data;
    logic              mem_stall, redirect_valid;
    logic              pipeval;
    logic [4:0]        rs1, rs2, rd;
    logic [63:0]       src1, src2, imm;
    logic              src1_is_reg, src2_is_reg, need_to_wb;
    logic [CTRL_W-1:0] ctrl;
    logic [63:0]       pc;
    logic [31:0]       instr;
    logic [2:0]        count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    // Register file model: x0 reads 0, xN reads 0x1000+N
    assign rf_rs1_data = (rf_rs1_addr == 5'd0) ? 64'd0 : 64'h1000 + {59'd0, rf_rs1_addr};
    assign rf_rs2_data = (rf_rs2_addr == 5'd0) ? 64'd0 : 64'h1000 + {59'd0, rf_rs2_addr};

    issue_stage #(.DEPTH(DEPTH), .WB_LAT(WB_LAT), .CTRL_W(CTRL_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_src1_is_reg(in_src1_is_reg), .in_src2_is_reg(in_src2_is_reg),
        .in_need_to_wb(in_need_to_wb),
        .in_imm(in_imm), .in_pc(in_pc), .in_instr(in_instr), .in_ctrl(in_ctrl),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .rf_write_valid(rf_write_valid), .rf_write_rd(rf_write_rd),
        .rf_write_data(rf_write_data),
        .mem_stall(mem_stall), .redirect_valid(redirect_valid),
        .pipeval(pipeval),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .src1(src1), .src2(src2), .imm(imm),
        .src1_is_reg(src1_is_reg), .src2_is_reg(src2_is_reg), .need_to_wb(need_to_wb),
        .ctrl(ctrl), .pc(pc), .instr(instr), .count(count)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [63:0] pc_v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input logic r1reg, input logic r2reg,
                        input logic wb);
        in_valid       = 1'b1;
        in_pc          = pc_v;
        in_rs1         = r1;
        in_rs2         = r2;
        in_rd          = d;
        in_src1_is_reg = r1reg;
        in_src2_is_reg = r2reg;
        in_need_to_wb  = wb;
        in_imm         = pc_v ^ 64'h55;
        in_instr       = pc_v[31:0] + 32'h13;
        in_ctrl        = ~pc_v[31:0];
    endtask

    task automatic no_push();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        no_push();
        mem_stall      = 1'b0;
        redirect_valid = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (pipeval !== 1'b0) begin n_bad++; $display("FAIL reset_pipeval got %b want 0", pipeval); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (src1 !== 64'd0) begin n_bad++; $display("FAIL reset_src1 got %h want 0", src1); end
        n_cmp++; if (pc !== 64'd0) begin n_bad++; $display("FAIL reset_pc got %h want 0", pc); end
        n_cmp++; if (ctrl !== '0) begin n_bad++; $display("FAIL reset_ctrl got %h want 0", ctrl); end
        n_cmp++; if (rd !== 5'd0) begin n_bad++; $display("FAIL reset_rd got %0d want 0", rd); end
        $display("reset: count=%0d pipeval=%b in_ready=%b", count, pipeval, in_ready);
    endtask

    task automatic test_independent();
        logic [63:0] exp_pc;
        for (int i = 0; i < 5; i++) begin
            exp_pc = 64'h100 + 64'(4 * i);
            if (i < 4) push(exp_pc, 5'd1, 5'd2, 5'(10 + i), 1'b1, 1'b1, 1'b1);
            else       no_push();
            step();
            if (i < 4) begin
                n_cmp++; if (pipeval !== 1'b1) begin n_bad++; $display("FAIL indep_pipeval[%0d] got %b want 1", i, pipeval); end
                n_cmp++; if (pc !== exp_pc) begin n_bad++; $display("FAIL indep_pc[%0d] got %h want %h", i, pc, exp_pc); end
                n_cmp++; if (src1 !== 64'h1001) begin n_bad++; $display("FAIL indep_src1[%0d] got %h want 1001", i, src1); end
                n_cmp++; if (imm !== (exp_pc ^ 64'h55)) begin n_bad++; $display("FAIL indep_imm[%0d] got %h want %h", i, imm, exp_pc ^ 64'h55); end
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL indep_in_ready[%0d] got %b want 1", i, in_ready); end
                $display("indep: issue pc=%h rd=%0d", pc, rd);
            end else begin
                n_cmp++; if (pipeval !== 1'b0) begin n_bad++; $display("FAIL indep_empty_pipeval got %b want 0", pipeval); end
            end
        end
    endtask

    task automatic test_dependent();
        int prod_cyc = -1;
        int cons_cyc = -1;
        rf_write_valid = 1'b1;
        rf_write_rd    = 5'd5;
        rf_write_data  = 64'hDEAD_BEEF;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc == 0)      push(64'h200, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1);
            else if (cyc == 1) push(64'h204, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1);
            else               no_push();
            step();
            if (pipeval && pc == 64'h200) prod_cyc = cyc;
            if (pipeval && pc == 64'h204 && cons_cyc < 0) begin
                cons_cyc = cyc;
                n_cmp++;
                if (src1 !== (BYP ? 64'hDEAD_BEEF : 64'h1005)) begin
                    n_bad++; $display("FAIL dep_src1 got %h want %h", src1, BYP ? 64'hDEAD_BEEF : 64'h1005);
                end
            end
        end
        rf_write_valid = 1'b0;
        n_cmp++; if (prod_cyc != 0) begin n_bad++; $display("FAIL dep_prod_cycle got %0d want 0", prod_cyc); end
        n_cmp++; if (cons_cyc != DEP_GAP) begin n_bad++; $display("FAIL dep_cons_cycle got %0d want %0d", cons_cyc, DEP_GAP); end
        $display("dependent: producer cycle %0d consumer cycle %0d", prod_cyc, cons_cyc);
    endtask

    task automatic test_full_stall();
        bit drained = 1'b0;
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(64'h300 + 64'(4 * i), 5'd1, 5'd2, 5'(20 + i), 1'b1, 1'b1, 1'b1);
            step();
        end
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL full_count got %0d want 4", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        n_cmp++; if (pipeval !== 1'b0) begin n_bad++; $display("FAIL full_stalled_pipeval got %b want 0", pipeval); end
        push(64'h310, 5'd1, 5'd2, 5'd24, 1'b1, 1'b1, 1'b1);
        mem_stall = 1'b0;
        #1;
        n_cmp++; if (pipeval !== 1'b1) begin n_bad++; $display("FAIL full_pop_pipeval got %b want 1", pipeval); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_pop_in_ready got %b want 0", in_ready); end
        step();
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL full_after_pop_count got %0d want 3", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL full_after_pop_in_ready got %b want 1", in_ready); end
        n_cmp++; if (pc !== 64'h304) begin n_bad++; $display("FAIL full_after_pop_pc got %h want 304", pc); end
        step();
        no_push();
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL full_push_count got %0d want 3", count); end
        for (int i = 0; i < 10 && !drained; i++) begin
            step();
            if (count == 3'd0) drained = 1'b1;
        end
        n_cmp++; if (!drained) begin n_bad++; $display("FAIL full_drain got count %0d want 0", count); end
        $display("full_stall: drained=%b", drained);
    endtask

    task automatic test_redirect();
        int cons_cyc = -1;
        bit leaked = 1'b0;
        mem_stall = 1'b1;
        push(64'h400, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            push(64'h404 + 64'(4 * i), 5'd1, 5'd2, 5'(21 + i), 1'b1, 1'b1, 1'b1);
            step();
        end
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL redir_prefill_count got %0d want 4", count); end
        push(64'h500, 5'd1, 5'd2, 5'd25, 1'b1, 1'b1, 1'b1);
        mem_stall      = 1'b0;
        redirect_valid = 1'b1;
        #1;
        n_cmp++; if (pipeval !== 1'b1 || pc !== 64'h400) begin n_bad++; $display("FAIL redir_branch_issue got pipeval=%b pc=%h want 1/400", pipeval, pc); end
        step();
        redirect_valid = 1'b0;
        no_push();
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL redir_count got %0d want 0", count); end
        n_cmp++; if (pipeval !== 1'b0) begin n_bad++; $display("FAIL redir_pipeval got %b want 0", pipeval); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL redir_in_ready got %b want 1", in_ready); end
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc == 0) push(64'h410, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);
            else          no_push();
            step();
            if (pipeval) begin
                if (pc != 64'h410) leaked = 1'b1;
                else if (cons_cyc < 0) begin
                    cons_cyc = cyc;
                    n_cmp++; if (src1 !== 64'h1007) begin n_bad++; $display("FAIL redir_cons_src1 got %h want 1007", src1); end
                end
            end
        end
        n_cmp++; if (leaked) begin n_bad++; $display("FAIL redir_younger_issued got 1 want 0"); end
        n_cmp++; if (cons_cyc != DEP_GAP - 2) begin n_bad++; $display("FAIL redir_slot0_hazard got cycle %0d want %0d", cons_cyc, DEP_GAP - 2); end
        $display("redirect: consumer of branch rd issued at cycle %0d", cons_cyc);
    endtask

    task automatic test_x0();
        int prod_cyc = -1;
        int cons_cyc = -1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 0)      push(64'h600, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1);
            else if (cyc == 1) push(64'h604, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1);
            else               no_push();
            step();
            if (pipeval && pc == 64'h600) prod_cyc = cyc;
            if (pipeval && pc == 64'h604 && cons_cyc < 0) begin
                cons_cyc = cyc;
                n_cmp++; if (src1 !== 64'd0) begin n_bad++; $display("FAIL x0_src1 got %h want 0", src1); end
            end
        end
        n_cmp++; if (prod_cyc != 0 || cons_cyc != 1) begin n_bad++; $display("FAIL x0_no_stall got %0d/%0d want 0/1", prod_cyc, cons_cyc); end
        $display("x0: producer %0d consumer %0d", prod_cyc, cons_cyc);
    endtask

    task automatic test_reset_mid();
        int cons_cyc = -1;
        mem_stall = 1'b1;
        push(64'h700, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            push(64'h704 + 64'(4 * i), 5'd1, 5'd2, 5'(24 + i), 1'b1, 1'b1, 1'b1);
            step();
        end
        mem_stall = 1'b0;
        no_push();
        step();
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("FAIL rmid_pre_count got %0d want 3", count); end
        reset          = 1'b1;
        redirect_valid = 1'b1;
        push(64'h7F0, 5'd1, 5'd2, 5'd30, 1'b1, 1'b1, 1'b1);
        step();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        no_push();
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL rmid_count got %0d want 0", count); end
        n_cmp++; if (pipeval !== 1'b0) begin n_bad++; $display("FAIL rmid_pipeval got %b want 0", pipeval); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc == 0) push(64'h720, 5'd9, 5'd24, 5'd10, 1'b1, 1'b1, 1'b1);
            else          no_push();
            step();
            if (pipeval && pc == 64'h720 && cons_cyc < 0) cons_cyc = cyc;
        end
        n_cmp++; if (cons_cyc != 0) begin n_bad++; $display("FAIL rmid_slots_cleared got cycle %0d want 0", cons_cyc); end
        $display("reset_mid: post-reset consumer issued at cycle %0d", cons_cyc);
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_rs1         = '0;
        in_rs2         = '0;
        in_rd          = '0;
        in_src1_is_reg = 1'b0;
        in_src2_is_reg = 1'b0;
        in_need_to_wb  = 1'b0;
        in_imm         = '0;
        in_pc          = '0;
        in_instr       = '0;
        in_ctrl        = '0;
        rf_write_valid = 1'b0;
        rf_write_rd    = '0;
        rf_write_data  = '0;
        mem_stall      = 1'b0;
        redirect_valid = 1'b0;

        test_reset();
        test_independent();
        drain();
        test_dependent();
        drain();
        test_full_stall();
        drain();
        test_redirect();
        drain();
        test_x0();
        drain();
        test_reset_mid();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
